// File: rtl/flex_counter.sv
// flex_counter: up-counter with a run-time terminal count, synchronous clear,
// count enable and a registered flag that is high while the count sits at the
// terminal value. The count wraps to 1 rather than 0, so the period is exactly
// rollover_val cycles once running.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    next_flag;

    // Advance one step. A count at or above the terminal value wraps to 1, which
    // also recovers cleanly when rollover_val is lowered below the current count.
    // The increment cannot overflow because the wrap fires at most at 2^N-1.
    function automatic logic [NUM_CNT_BITS-1:0] advance(
        input logic [NUM_CNT_BITS-1:0] cnt,
        input logic [NUM_CNT_BITS-1:0] term
    );
        if (cnt < term) begin
            return cnt + CNT_ONE;
        end
        return CNT_ONE;
    endfunction

    // Next-state selection: clear beats enable, enable beats hold. The flag is
    // judged against the value the count is about to take so that it lines up
    // with that count; during hold this makes it follow rollover_val changes.
    always_comb begin
        next_count = count_out;
        next_flag  = 1'b0;
        if (clear) begin
            next_count = CNT_ZERO;
            next_flag  = 1'b0;
        end else begin
            if (count_enable) begin
                next_count = advance(count_out, rollover_val);
            end
            next_flag = (next_count == rollover_val);
        end
    end

    // Count and flag registers; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            count_out     <= CNT_ZERO;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= next_flag;
        end
    end

endmodule

// File: tb/tb_flex_counter.sv
// Self-checking bench for flex_counter: directed scenarios plus a randomized
// run, all compared against a behavioural model of the counting rules.
module tb_flex_counter;

    logic       tb_clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       count_enable = 1'b0;
    logic [3:0] rollover_val = 4'd0;
    logic [3:0] count_out;
    logic       rollover_flag;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mc = 0;
    int mf = 0;

    flex_counter #(.NUM_CNT_BITS(4)) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag)
    );

    // 10-unit clock; inputs change and outputs are sampled on the falling edge
    always #5 tb_clk = ~tb_clk;

    // One rising edge: apply the counting rules to the model, then return at the
    // following falling edge where the bench samples and drives.
    task automatic tick();
        int r;
        @(posedge tb_clk);
        r = int'(rollover_val);
        if (n_rst) begin
            mc = 0; mf = 0;
        end else if (clear) begin
            mc = 0; mf = 0;
        end else begin
            if (count_enable) mc = (mc < r) ? mc + 1 : 1;
            mf = (mc == r) ? 1 : 0;
        end
        @(negedge tb_clk);
    endtask

    task automatic test_reset();
        #1 n_rst = 1'b1;
        #1;
        checks++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_async count=%0d flag=%0b required count=0 flag=0", count_out, rollover_flag);
        end
        rollover_val = 4'd5;
        count_enable = 1'b1;
        @(posedge tb_clk);
        #1;
        checks++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_edge count=%0d flag=%0b required count=0 flag=0", count_out, rollover_flag);
        end
        @(negedge tb_clk);
        mc = 0; mf = 0;
        count_enable = 1'b0;
        n_rst = 1'b0;
        #2;
        checks++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_release count=%0d flag=%0b required count=0 flag=0", count_out, rollover_flag);
        end
        @(negedge tb_clk);
        tick();
        checks++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_after count=%0d flag=%0b required count=0 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_rollover_nine();
        clear = 1'b1; tick(); clear = 1'b0;
        rollover_val = 4'd9;
        count_enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (int'(count_out) !== i || rollover_flag !== (i == 9)) begin
                errors++;
                $display("FAIL roll9_step%0d count=%0d flag=%0b required count=%0d flag=%0b",
                         i, count_out, rollover_flag, i, (i == 9));
            end
        end
        tick();
        checks++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL roll9_wrap count=%0d flag=%0b required count=1 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_sweep();
        int vals[$];
        int last_hit;
        int hits;
        int r;
        for (int v = 0; v <= 14; v++) vals.push_back(v);
        vals.push_back(3); vals.push_back(5); vals.push_back(1);
        vals.push_back(9); vals.push_back(11); vals.push_back(13);
        foreach (vals[k]) begin
            r = vals[k];
            clear = 1'b1; count_enable = 1'b1; tick(); clear = 1'b0;
            rollover_val = 4'(r);
            last_hit = -1;
            hits = 0;
            for (int t = 1; t <= 3 * r + 4; t++) begin
                tick();
                checks++;
                if (int'(count_out) !== mc || int'(rollover_flag) !== mf) begin
                    errors++;
                    $display("FAIL sweep_R%0d_t%0d count=%0d flag=%0b required count=%0d flag=%0d",
                             r, t, count_out, rollover_flag, mc, mf);
                end
                if (rollover_flag === 1'b1) begin
                    if (last_hit >= 0) begin
                        checks++;
                        if (t - last_hit != r) begin
                            errors++;
                            $display("FAIL sweep_period_R%0d period=%0d required %0d", r, t - last_hit, r);
                        end
                    end
                    last_hit = t;
                    hits++;
                end
            end
            if (r >= 1) begin
                checks++;
                if (hits < 2) begin
                    errors++;
                    $display("FAIL sweep_flag_hits_R%0d hits=%0d required at least 2", r, hits);
                end
            end else begin
                checks++;
                if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_R0_stick count=%0d flag=%0b required count=1 flag=0", count_out, rollover_flag);
                end
            end
        end
    endtask

    task automatic test_continuous();
        int guard;
        clear = 1'b1; tick(); clear = 1'b0;
        rollover_val = 4'd15;
        count_enable = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            tick();
            checks++;
            if (int'(count_out) !== ((t - 1) % 15) + 1 || rollover_flag !== (((t - 1) % 15) == 14)) begin
                errors++;
                $display("FAIL cont_t%0d count=%0d flag=%0b required count=%0d flag=%0b",
                         t, count_out, rollover_flag, ((t - 1) % 15) + 1, (((t - 1) % 15) == 14));
            end
        end
        guard = 0;
        while (count_out != 4'd12 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (count_out !== 4'd12) begin
            errors++;
            $display("FAIL cont_reach12 count=%0d required 12 within 20 edges", count_out);
        end
        rollover_val = 4'd7;
        tick();
        checks++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL cont_lower_wrap count=%0d flag=%0b required count=1 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_discontinuous();
        logic [3:0] held;
        logic       held_flag;
        clear = 1'b1; tick(); clear = 1'b0;
        rollover_val = 4'd10;
        count_enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        count_enable = 1'b0;
        held = count_out;
        held_flag = rollover_flag;
        checks++;
        if (held !== 4'd6) begin
            errors++;
            $display("FAIL disc_start count=%0d required 6", held);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if (count_out !== held || rollover_flag !== held_flag) begin
                errors++;
                $display("FAIL disc_hold_%0d count=%0d flag=%0b required count=%0d flag=%0b",
                         i, count_out, rollover_flag, held, held_flag);
            end
        end
        count_enable = 1'b1;
        tick();
        checks++;
        if (count_out !== 4'd7 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL disc_resume count=%0d flag=%0b required count=7 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        rollover_val = 4'd4;
        count_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (count_out !== 4'd4 || rollover_flag !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre count=%0d flag=%0b required count=4 flag=1", count_out, rollover_flag);
        end
        for (int i = 0; i < 4; i++) begin
            clear = 1'b1;
            count_enable = (i % 2 == 0);
            tick();
            checks++;
            if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
                errors++;
                $display("FAIL clr_pulse_%0d count=%0d flag=%0b required count=0 flag=0", i, count_out, rollover_flag);
            end
        end
        clear = 1'b0;
        count_enable = 1'b1;
        tick();
        checks++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL clr_release count=%0d flag=%0b required count=1 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_reset_mid();
        clear = 1'b1; tick(); clear = 1'b0;
        rollover_val = 4'd12;
        count_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count_out !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_pre count=%0d required 5", count_out);
        end
        #2 n_rst = 1'b1;
        #1;
        checks++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async count=%0d flag=%0b required count=0 flag=0", count_out, rollover_flag);
        end
        @(negedge tb_clk);
        tick();
        n_rst = 1'b0;
        mc = 0; mf = 0;
        tick();
        checks++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resume count=%0d flag=%0b required count=1 flag=0", count_out, rollover_flag);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            count_enable = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) rollover_val = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (int'(count_out) !== mc || int'(rollover_flag) !== mf) begin
                errors++;
                $display("FAIL random_%0d count=%0d flag=%0b required count=%0d flag=%0d",
                         i, count_out, rollover_flag, mc, mf);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rollover_nine();
        test_sweep();
        test_continuous();
        test_discontinuous();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
